// File: rtl/trackball_reader.sv
// Trackball input stage: synchronizes and glitch-filters both players' quadrature lines,
// keeps 4-bit position counters per axis and muxes the selected ball onto IN0/IN1.
module trackball_reader #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       hordir1,
  input  logic       horclk1,
  input  logic       verdir1,
  input  logic       verclk1,
  input  logic       hordir2,
  input  logic       horclk2,
  input  logic       verdir2,
  input  logic       verclk2,
  input  logic       tb_flip,
  input  logic       steerclr_l,
  output logic [7:0] in0_data,
  output logic [7:0] in1_data
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);

  // Line order: even = dir, odd = clock; axis a uses lines 2a (dir) and 2a+1 (clock).
  logic [7:0]             w_pins;
  logic [SYNC_STAGES-1:0] r_sync [8];
  logic [7:0]             w_synced;
  logic [7:0]             r_filt;
  logic [FCW-1:0]         r_fcnt [8];
  logic [SYNC_STAGES-1:0] r_settle;
  logic [3:0]             r_armed;
  logic [3:0]             r_prev;
  logic [3:0]             r_dir;
  logic [3:0]             r_cnt [4];
  logic [3:0]             w_clk_f;
  logic [3:0]             w_dir_f;
  logic [3:0]             w_clk_s;
  logic [3:0]             w_rise;

  assign w_pins = {verclk2, verdir2, horclk2, hordir2, verclk1, verdir1, horclk1, hordir1};

  always_comb begin
    w_synced = '0;
    for (int unsigned i = 0; i < 8; i++) w_synced[i] = r_sync[i][SYNC_STAGES-1];
  end

  always_comb begin
    w_clk_f = '0;
    w_dir_f = '0;
    w_clk_s = '0;
    w_rise  = '0;
    for (int unsigned a = 0; a < 4; a++) begin
      w_clk_f[a] = r_filt[2*a+1];
      w_dir_f[a] = r_filt[2*a];
      w_clk_s[a] = w_synced[2*a+1];
      w_rise[a]  = w_clk_f[a] & ~r_prev[a] & r_armed[a];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_settle <= '0;
      r_filt   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_sync[i] <= '0;
        r_fcnt[i] <= '0;
      end
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      for (int unsigned i = 0; i < 8; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_pins[i]};
        if (w_synced[i] != r_filt[i]) begin
          if (r_fcnt[i] == FLAST) begin
            r_filt[i] <= w_synced[i];
            r_fcnt[i] <= '0;
          end else begin
            r_fcnt[i] <= r_fcnt[i] + FCW'(1);
          end
        end else begin
          r_fcnt[i] <= '0;
        end
      end
    end
  end

  // Arming waits until the sync chain holds real pin samples (r_settle) and the line is
  // genuinely low, so a clock held high across reset release never yields a count.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_armed <= '0;
      r_prev  <= '0;
      r_dir   <= '0;
      for (int unsigned a = 0; a < 4; a++) r_cnt[a] <= '0;
    end else begin
      r_prev <= w_clk_f;
      for (int unsigned a = 0; a < 4; a++) begin
        if (r_settle[SYNC_STAGES-1] && !w_clk_f[a] && !w_clk_s[a]) r_armed[a] <= 1'b1;
        r_cnt[a] <= (steerclr_l ? r_cnt[a] : 4'h0) +
                    (w_rise[a] ? (w_dir_f[a] ? 4'h1 : 4'hF) : 4'h0);
        if (w_rise[a]) r_dir[a] <= w_dir_f[a];
      end
    end
  end

  always_comb begin
    if (tb_flip) begin
      in0_data = {r_dir[2], 3'b000, r_cnt[2]};
      in1_data = {r_dir[3], 3'b000, r_cnt[3]};
    end else begin
      in0_data = {r_dir[0], 3'b000, r_cnt[0]};
      in1_data = {r_dir[1], 3'b000, r_cnt[1]};
    end
  end

endmodule

// File: tb/tb_trackball_reader.sv
// Bench for trackball_reader: directed scenarios plus randomized pulses checked against
// a pulse-level model (each clean pulse moves its counter by +/-1, glitches are ignored).
module tb_trackball_reader;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [7:0] r_pins;
  logic       tb_flip;
  logic       steerclr_l;
  logic [7:0] in0_data;
  logic [7:0] in1_data;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_cnt [4];
  logic       m_dir [4];

  always #5 clk = ~clk;

  trackball_reader #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .hordir1    (r_pins[0]),
    .horclk1    (r_pins[1]),
    .verdir1    (r_pins[2]),
    .verclk1    (r_pins[3]),
    .hordir2    (r_pins[4]),
    .horclk2    (r_pins[5]),
    .verdir2    (r_pins[6]),
    .verclk2    (r_pins[7]),
    .tb_flip    (tb_flip),
    .steerclr_l (steerclr_l),
    .in0_data   (in0_data),
    .in1_data   (in1_data)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int clk_line, input int hi, input int lo);
    r_pins[clk_line] = 1'b1;
    tick(hi);
    r_pins[clk_line] = 1'b0;
    tick(lo);
  endtask

  function automatic void model_reset();
    for (int a = 0; a < 4; a++) begin
      m_cnt[a] = 4'h0;
      m_dir[a] = 1'b0;
    end
  endfunction

  function automatic void model_move(input int a, input logic d);
    m_cnt[a] = d ? m_cnt[a] + 4'h1 : m_cnt[a] - 4'h1;
    m_dir[a] = d;
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    return {m_dir[a], 3'b000, m_cnt[a]};
  endfunction

  task automatic test_reset();
    r_pins = 8'hFF; tb_flip = 1'b0; steerclr_l = 1'b1; rst_l = 1'b0;
    model_reset();
    tick(3);
    checks++;
    if (in0_data !== 8'h00 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold in0=%h in1=%h exp=00/00", in0_data, in1_data);
    end
    rst_l = 1'b1;
    tick(30);
    checks++;
    if (in0_data !== 8'h00 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_lines_high in0=%h in1=%h exp=00/00", in0_data, in1_data);
    end
    tb_flip = 1'b1;
    #1;
    checks++;
    if (in0_data !== 8'h00 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_lines_high_p2 in0=%h in1=%h exp=00/00", in0_data, in1_data);
    end
    tb_flip = 1'b0;
    r_pins = 8'h00;
    tick(20);
    checks++;
    if (in0_data !== 8'h00 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_lines_fall in0=%h in1=%h exp=00/00", in0_data, in1_data);
    end
  endtask

  task automatic test_up_count();
    logic [7:0] exp;
    r_pins[0] = 1'b1;
    tick(10);
    r_pins[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k < 7) ? 8'h00 : 8'h81;
      checks++;
      if (in0_data !== exp) begin
        failures++;
        $display("FAIL latency_edge%0d in0=%h exp=%h", k, in0_data, exp);
      end
    end
    tick(3);
    r_pins[1] = 1'b0;
    tick(10);
    model_move(0, 1'b1);
    pulse(1, 10, 10);
    model_move(0, 1'b1);
    pulse(1, 10, 10);
    model_move(0, 1'b1);
    checks++;
    if (in0_data !== 8'h83) begin
      failures++;
      $display("FAIL up_count in0=%h exp=83", in0_data);
    end
    checks++;
    if (in1_data !== 8'h00) begin
      failures++;
      $display("FAIL up_count_other_axis in1=%h exp=00", in1_data);
    end
  endtask

  task automatic test_wrap();
    r_pins[2] = 1'b1;
    tick(10);
    for (int p = 0; p < 17; p++) begin
      pulse(3, 6, 6);
      model_move(1, 1'b1);
    end
    tick(4);
    checks++;
    if (in1_data !== 8'h81) begin
      failures++;
      $display("FAIL wrap_up in1=%h exp=81", in1_data);
    end
    r_pins[2] = 1'b0;
    tick(10);
    for (int p = 0; p < 2; p++) begin
      pulse(3, 6, 6);
      model_move(1, 1'b0);
    end
    tick(4);
    checks++;
    if (in1_data !== 8'h0F) begin
      failures++;
      $display("FAIL wrap_down in1=%h exp=0f", in1_data);
    end
  endtask

  task automatic test_glitch();
    r_pins[4] = 1'b1;
    tick(10);
    tb_flip = 1'b1;
    pulse(5, 3, 10);
    checks++;
    if (in0_data !== 8'h00) begin
      failures++;
      $display("FAIL glitch_3cyc in0=%h exp=00", in0_data);
    end
    pulse(5, 4, 10);
    model_move(2, 1'b1);
    checks++;
    if (in0_data !== 8'h81) begin
      failures++;
      $display("FAIL glitch_4cyc in0=%h exp=81", in0_data);
    end
    tb_flip = 1'b0;
  endtask

  task automatic test_clear_race();
    pulse(1, 10, 10);
    model_move(0, 1'b1);
    pulse(1, 10, 10);
    model_move(0, 1'b1);
    checks++;
    if (in0_data !== 8'h85) begin
      failures++;
      $display("FAIL clear_race_pre in0=%h exp=85", in0_data);
    end
    r_pins[1] = 1'b1;
    tick(6);
    steerclr_l = 1'b0;
    tick(1);
    steerclr_l = 1'b1;
    for (int a = 0; a < 4; a++) m_cnt[a] = 4'h0;
    model_move(0, 1'b1);
    checks++;
    if (in0_data !== 8'h81 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL clear_race_p1 in0=%h in1=%h exp=81/00", in0_data, in1_data);
    end
    tb_flip = 1'b1;
    #1;
    checks++;
    if (in0_data !== model_byte(2) || in1_data !== model_byte(3)) begin
      failures++;
      $display("FAIL clear_race_p2 in0=%h in1=%h exp=%h/%h", in0_data, in1_data,
               model_byte(2), model_byte(3));
    end
    tb_flip = 1'b0;
    tick(3);
    r_pins[1] = 1'b0;
    tick(10);
  endtask

  task automatic test_ball_select();
    pulse(1, 10, 10);
    model_move(0, 1'b1);
    for (int p = 0; p < 9; p++) begin
      pulse(5, 6, 6);
      model_move(2, 1'b1);
    end
    tick(4);
    checks++;
    if (in0_data !== 8'h82) begin
      failures++;
      $display("FAIL select_p1 in0=%h exp=82", in0_data);
    end
    tb_flip = 1'b1;
    #1;
    checks++;
    if (in0_data !== 8'h89) begin
      failures++;
      $display("FAIL select_p2_same_cycle in0=%h exp=89", in0_data);
    end
    tb_flip = 1'b0;
    #1;
    checks++;
    if (in0_data !== 8'h82) begin
      failures++;
      $display("FAIL select_back_p1 in0=%h exp=82", in0_data);
    end
    tick(5);
    tb_flip = 1'b1;
    #1;
    checks++;
    if (in0_data !== 8'h89) begin
      failures++;
      $display("FAIL select_p2_stable in0=%h exp=89", in0_data);
    end
    tb_flip = 1'b0;
    tick(1);
  endtask

  task automatic test_simultaneous();
    logic d [4];
    for (int a = 0; a < 4; a++) begin
      d[a] = 1'($urandom_range(0, 1));
      r_pins[2*a]   = d[a];
      r_pins[2*a+1] = 1'b1;
    end
    tick(8);
    for (int a = 0; a < 4; a++) begin
      r_pins[2*a+1] = 1'b0;
      model_move(a, d[a]);
    end
    tick(10);
    for (int f = 0; f < 2; f++) begin
      tb_flip = 1'(f);
      #1;
      checks++;
      if (in0_data !== model_byte(2*f) || in1_data !== model_byte(2*f+1)) begin
        failures++;
        $display("FAIL simultaneous flip=%0d in0=%h in1=%h exp=%h/%h", f, in0_data, in1_data,
                 model_byte(2*f), model_byte(2*f+1));
      end
    end
    tb_flip = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    int   a;
    int   w;
    logic d;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        steerclr_l = 1'b0;
        tick($urandom_range(1, 3));
        steerclr_l = 1'b1;
        for (int k = 0; k < 4; k++) m_cnt[k] = 4'h0;
      end
      a = $urandom_range(0, 3);
      d = 1'($urandom_range(0, 1));
      w = $urandom_range(1, 8);
      r_pins[2*a] = d;
      pulse(2*a+1, w, 10);
      if (w >= 4) model_move(a, d);
      for (int f = 0; f < 2; f++) begin
        tb_flip = 1'(f);
        #1;
        checks++;
        if (in0_data !== model_byte(2*f) || in1_data !== model_byte(2*f+1)) begin
          failures++;
          $display("FAIL random it=%0d axis=%0d w=%0d flip=%0d in0=%h in1=%h exp=%h/%h", it, a,
                   w, f, in0_data, in1_data, model_byte(2*f), model_byte(2*f+1));
        end
      end
      tb_flip = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_midop_reset();
    r_pins[1] = 1'b1;
    tick(4);
    rst_l = 1'b0;
    model_reset();
    #1;
    checks++;
    if (in0_data !== 8'h00 || in1_data !== 8'h00) begin
      failures++;
      $display("FAIL midop_reset_async in0=%h in1=%h exp=00/00", in0_data, in1_data);
    end
    tick(3);
    rst_l = 1'b1;
    tick(15);
    checks++;
    if (in0_data !== 8'h00) begin
      failures++;
      $display("FAIL midop_held_high in0=%h exp=00", in0_data);
    end
    r_pins[1] = 1'b0;
    r_pins[0] = 1'b1;
    tick(10);
    checks++;
    if (in0_data !== 8'h00) begin
      failures++;
      $display("FAIL midop_release_low in0=%h exp=00", in0_data);
    end
    pulse(1, 6, 10);
    model_move(0, 1'b1);
    checks++;
    if (in0_data !== model_byte(0) || in1_data !== model_byte(1)) begin
      failures++;
      $display("FAIL midop_rearmed in0=%h in1=%h exp=%h/%h", in0_data, in1_data,
               model_byte(0), model_byte(1));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_glitch();
    test_clear_race();
    test_ball_select();
    test_simultaneous();
    test_random();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
